// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the uart host command decoder.
package uart_cmd_pkg;

  // Header byte layout: {we, addr[6:0]}
  localparam int unsigned CMD_WE_BIT = 7;
  localparam int unsigned CMD_ADDR_W = 7;
  localparam int unsigned WORD_BYTES = 4;

  // Baud constants shared with the uart module.
  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned BAUD_RATE  = 9600;
  localparam int unsigned FRAME_BITS = 10;

  // Inter-byte gap limit, roughly two frames at 9600 baud.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 110_000;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StWcommit,
    StRreq,
    StRwait,
    StRsend
  } cmd_state_e;

  // Byte lane idx of a 32-bit word, lane 0 is the LSB.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte gap counter. Clears while `clear` is high, otherwise counts while
// `enable` is high and saturates at TIMEOUT_CYCLES-1, where `expired` is raised.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 110_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt;

  assign expired = (cnt == CntW'(TIMEOUT_CYCLES - 1));

  // Gap counter with synchronous clear and saturation at terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Host byte protocol decoder: turns uart rx bytes into memory write/read strobes
// and streams read data back to the uart transmitter.
// Optional inter-byte timeout on write data is enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned RESP_BYTES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [CMD_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout_err
);
  localparam logic [1:0] LastData = 2'(WORD_BYTES - 1);
  localparam logic [1:0] LastResp = 2'(RESP_BYTES - 1);

  cmd_state_e  state;
  logic [1:0]  byte_cnt;
  logic [31:0] rdata_reg;
  logic        rx_dropped;

  // Bytes arriving while a command is being committed or answered are lost.
  assign rx_dropped = rx_valid && (state != StIdle) && (state != StWdata);
  assign busy       = (state != StIdle);

`ifdef CMD_TIMEOUT_EN
  logic gap_expired;

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid || (state != StWdata)),
    .enable (state == StWdata),
    .expired(gap_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

  // Command FSM with registered strobes, response stream and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      overrun   <= 1'b0;
      byte_cnt  <= '0;
      rdata_reg <= '0;
`ifdef CMD_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      if (rx_dropped) begin
        overrun <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (rx_valid) begin
            mem_addr <= rx_data[CMD_ADDR_W-1:0];
            byte_cnt <= '0;
            if (rx_data[CMD_WE_BIT]) begin
              state <= StWdata;
            end else begin
              state  <= StRreq;
              mem_re <= 1'b1;
            end
          end
        end
        StWdata: begin
          if (rx_valid) begin
            mem_wdata[8*byte_cnt +: 8] <= rx_data;
            if (byte_cnt == LastData) begin
              byte_cnt <= '0;
              state    <= StWcommit;
              mem_we   <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
`ifdef CMD_TIMEOUT_EN
          // A byte on the terminal-count cycle takes priority over the timeout.
          else if (gap_expired) begin
            byte_cnt    <= '0;
            state       <= StIdle;
            timeout_err <= 1'b1;
          end
`endif
        end
        StWcommit: begin
          state <= StIdle;
        end
        StRreq: begin
          state <= StRwait;
        end
        StRwait: begin
          // Read data is valid exactly one cycle after mem_re.
          rdata_reg <= mem_rdata;
          byte_cnt  <= '0;
          tx_data   <= word_byte(mem_rdata, 2'd0);
          tx_valid  <= 1'b1;
          state     <= StRsend;
        end
        StRsend: begin
          if (tx_ready) begin
            if (byte_cnt == LastResp) begin
              byte_cnt <= '0;
              tx_valid <= 1'b0;
              state    <= StIdle;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              tx_data  <= word_byte(rdata_reg, byte_cnt + 2'd1);
            end
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes expected memory strobes
// and tx bytes into queues; a negedge monitor pops and compares as the DUT acts.
// Two instances (RESP_BYTES=1 and 4) share the inputs; `sel` picks the active one.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          cyc;
  } wr_t;

  typedef struct packed {
    logic [6:0] addr;
    int         cyc;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_val = '0;
  logic        sel = 1'b0;

  logic [6:0]  d1_mem_addr, d4_mem_addr, mon_mem_addr;
  logic [31:0] d1_mem_wdata, d4_mem_wdata, mon_mem_wdata;
  logic        d1_mem_we, d4_mem_we, mon_mem_we;
  logic        d1_mem_re, d4_mem_re, mon_mem_re;
  logic [7:0]  d1_tx_data, d4_tx_data, mon_tx_data;
  logic        d1_tx_valid, d4_tx_valid, mon_tx_valid;
  logic        d1_busy, d4_busy, mon_busy;
  logic        d1_overrun, d4_overrun, mon_overrun;
  logic        d1_timeout_err, d4_timeout_err, mon_timeout_err;
  logic        rx_valid1, rx_valid4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rx = 0;
  int tx_start_exp = -1;
  bit tmo_allowed = 1'b0;

  wr_t        wq[$];
  rd_t        rq[$];
  logic [7:0] tq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: returns mem_val only in the cycle after mem_re, garbage otherwise.
  always @(posedge clk) mem_rdata <= mon_mem_re ? mem_val : 32'h5A5A_5A5A;

  assign rx_valid1       = rx_valid & ~sel;
  assign rx_valid4       = rx_valid & sel;
  assign mon_mem_addr    = sel ? d4_mem_addr : d1_mem_addr;
  assign mon_mem_wdata   = sel ? d4_mem_wdata : d1_mem_wdata;
  assign mon_mem_we      = sel ? d4_mem_we : d1_mem_we;
  assign mon_mem_re      = sel ? d4_mem_re : d1_mem_re;
  assign mon_tx_data     = sel ? d4_tx_data : d1_tx_data;
  assign mon_tx_valid    = sel ? d4_tx_valid : d1_tx_valid;
  assign mon_busy        = sel ? d4_busy : d1_busy;
  assign mon_overrun     = sel ? d4_overrun : d1_overrun;
  assign mon_timeout_err = sel ? d4_timeout_err : d1_timeout_err;

  uart_cmd_decoder #(
    .RESP_BYTES    (1),
    .TIMEOUT_CYCLES(50)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid1),
    .mem_addr   (d1_mem_addr),
    .mem_wdata  (d1_mem_wdata),
    .mem_we     (d1_mem_we),
    .mem_re     (d1_mem_re),
    .mem_rdata  (mem_rdata),
    .tx_data    (d1_tx_data),
    .tx_valid   (d1_tx_valid),
    .tx_ready   (tx_ready),
    .busy       (d1_busy),
    .overrun    (d1_overrun),
    .timeout_err(d1_timeout_err)
  );

  uart_cmd_decoder #(
    .RESP_BYTES    (4),
    .TIMEOUT_CYCLES(50)
  ) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid4),
    .mem_addr   (d4_mem_addr),
    .mem_wdata  (d4_mem_wdata),
    .mem_we     (d4_mem_we),
    .mem_re     (d4_mem_re),
    .mem_rdata  (mem_rdata),
    .tx_data    (d4_tx_data),
    .tx_valid   (d4_tx_valid),
    .tx_ready   (tx_ready),
    .busy       (d4_busy),
    .overrun    (d4_overrun),
    .timeout_err(d4_timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller sits just after a rising edge; returns just after the next one.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    last_rx  = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_write(input logic [6:0] a, input logic [31:0] w);
    wr_t e;
    e.addr  = a;
    e.wdata = w;
    e.cyc   = last_rx + 1;
    wq.push_back(e);
  endtask

  task automatic push_read(input logic [6:0] a);
    rd_t e;
    e.addr = a;
    e.cyc  = last_rx + 1;
    rq.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_mem_addr"}, mon_mem_addr, 0);
    chk({tag, "_mem_wdata"}, mon_mem_wdata, 0);
    chk({tag, "_mem_we"}, mon_mem_we, 0);
    chk({tag, "_mem_re"}, mon_mem_re, 0);
    chk({tag, "_tx_data"}, mon_tx_data, 0);
    chk({tag, "_tx_valid"}, mon_tx_valid, 0);
    chk({tag, "_busy"}, mon_busy, 0);
    chk({tag, "_overrun"}, mon_overrun, 0);
    chk({tag, "_timeout_err"}, mon_timeout_err, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  initial begin
    wr_t        w;
    rd_t        r;
    logic [7:0] t;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mon_mem_we) begin
          if (wq.size() == 0) chk("unexpected_mem_we", mon_mem_we, 0);
          else begin
            w = wq.pop_front();
            chk("wr_addr", mon_mem_addr, w.addr);
            chk("wr_data", mon_mem_wdata, w.wdata);
            chk("wr_cycle", cyc, w.cyc);
          end
        end
        if (mon_mem_re) begin
          if (rq.size() == 0) chk("unexpected_mem_re", mon_mem_re, 0);
          else begin
            r = rq.pop_front();
            chk("rd_addr", mon_mem_addr, r.addr);
            chk("rd_cycle", cyc, r.cyc);
            tx_start_exp = cyc + 2;
          end
        end
        if (mon_tx_valid && !prev_valid) begin
          chk("tx_start_cycle", cyc, tx_start_exp);
          tx_start_exp = -1;
        end
        if (prev_valid && !prev_ready) begin
          chk("tx_hold_valid", mon_tx_valid, 1);
          chk("tx_hold_data", mon_tx_data, prev_data);
        end
        if (mon_tx_valid && tx_ready) begin
          if (tq.size() == 0) chk("unexpected_tx", mon_tx_valid, 0);
          else begin
            t = tq.pop_front();
            chk("tx_data", mon_tx_data, t);
          end
        end
        if (mon_timeout_err && !tmo_allowed) chk("unexpected_timeout", mon_timeout_err, 0);
      end
      prev_valid = mon_tx_valid;
      prev_ready = tx_ready;
      prev_data  = mon_tx_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    // Reset state.
    idle(3);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // Write addr 5, word 0x20001234.
    send_byte(8'h85);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h00);
    send_byte(8'h20);
    push_write(7'h05, 32'h2000_1234);
    idle(4);
    chk("write_busy_after", mon_busy, 0);

    // Read addr 5, RESP_BYTES=1, transmitter stalled for 10+ cycles.
    mem_val  = 32'h0000_00AB;
    tx_ready = 1'b0;
    send_byte(8'h05);
    push_read(7'h05);
    tq.push_back(8'hAB);
    idle(1);
    chk("read_busy", mon_busy, 1);
    idle(12);
    @(negedge clk);
    chk("read_stall_valid", mon_tx_valid, 1);
    chk("read_stall_data", mon_tx_data, 8'hAB);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    idle(3);
    tx_ready = 1'b0;
    chk("read_busy_after", mon_busy, 0);

    // Overrun during RSEND, header addr 0x7F.
    mem_val = 32'h0000_0077;
    send_byte(8'h7F);
    push_read(7'h7F);
    tq.push_back(8'h77);
    idle(5);
    chk("overrun_before", mon_overrun, 0);
    send_byte(8'h99);
    chk("overrun_set", mon_overrun, 1);
    tx_ready = 1'b1;
    idle(3);
    tx_ready = 1'b0;
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    push_write(7'h7F, 32'h0403_0201);
    idle(3);
    chk("overrun_sticky", mon_overrun, 1);

    // RESP_BYTES=4 instance, with stalls between transfers.
    sel     = 1'b1;
    mem_val = 32'hDEAD_BEEF;
    send_byte(8'h10);
    push_read(7'h10);
    tq.push_back(8'hEF);
    tq.push_back(8'hBE);
    tq.push_back(8'hAD);
    tq.push_back(8'hDE);
    idle(2);
    for (int i = 0; i < 12; i++) begin
      tx_ready = (i % 3) != 0;
      idle(1);
    end
    tx_ready = 1'b0;
    chk("resp4_busy_after", mon_busy, 0);
    chk("resp4_overrun", mon_overrun, 0);

    // Reset in the middle of a write.
    sel = 1'b0;
    send_byte(8'h81);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b0;
    check_reset_outputs("midreset");
    idle(2);
    reset = 1'b1;
    idle(2);
    send_byte(8'h81);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    push_write(7'h01, 32'h4433_2211);
    idle(4);

`ifdef CMD_TIMEOUT_EN
    // Partial write abandoned: timeout pulse on gap cycle 50.
    send_byte(8'h82);
    send_byte(8'h55);
    tmo_allowed = 1'b1;
    seen = -1;
    for (int g = 0; g < 60 && seen < 0; g++) begin
      @(negedge clk);
      if (mon_timeout_err) seen = g;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("timeout_gap", seen, 50);
    chk("timeout_busy", mon_busy, 0);
    @(posedge clk);
    #1;
    tmo_allowed = 1'b0;
    @(negedge clk);
    chk("timeout_pulse_width", mon_timeout_err, 0);
    @(posedge clk);
    #1;

    // Byte on the terminal-count cycle keeps the command alive.
    send_byte(8'h82);
    send_byte(8'h11);
    idle(49);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    push_write(7'h02, 32'h4433_2211);
    idle(4);
`endif

    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("tq_drained", tq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Sits directly downstream of the uart receiver (rx byte stream) and upstream of its transmitter, inside cpu_top.
- Decodes the host byte protocol into memory-port operations:
  - write command: header {we=1, addr[6:0]}, then 4 data bytes, LSB first.
  - read command: header {we=0, addr[6:0]}.
- A write issues a single-cycle memory write.
- A read issues a memory read and streams RESP_BYTES bytes of the returned word, LSB first, back to the uart transmitter.

Parameters:
- RESP_BYTES, 1, bytes returned per read command (legal range 1..4, LSB first).
- TIMEOUT_CYCLES, 110000, inter-byte gap limit in clk cycles (about 2 frames at 9600 baud, 50 MHz); used only with CMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the uart receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- mem_addr  out  7  command address.
- mem_wdata  out  32  assembled write word.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  32  read data, valid exactly 1 cycle after mem_re.
- tx_data  out  8  response byte to the uart transmitter.
- tx_valid  out  1  response byte valid.
- tx_ready  in  1  transmitter accepts tx_data.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky flag: an rx byte was dropped.
- timeout_err  out  1  one-cycle pulse when a partial command is discarded (CMD_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
  - tx_data=0, tx_valid=0, busy=0, overrun=0, timeout_err=0.
  - byte_cnt=0, rdata_reg=0.
  - Reset mid-command aborts the command with no memory strobe.
- States: IDLE, WDATA, WCOMMIT, RREQ, RWAIT, RSEND.
- IDLE:
  - on rx_valid, latch mem_addr = rx_data[6:0].
  - rx_data[7]=1 -> WDATA with byte_cnt=0.
  - rx_data[7]=0 -> RREQ.
- WDATA:
  - on rx_valid, place rx_data into mem_wdata[8*byte_cnt +: 8] and increment byte_cnt.
  - after the 4th byte (byte_cnt was 3) -> WCOMMIT.
- WCOMMIT: mem_we=1 for exactly this cycle -> IDLE.
  - Latency: mem_we is asserted 1 cycle after the rx_valid of the last data byte.
- RREQ: mem_re=1 for exactly this cycle -> RWAIT.
- RWAIT: capture mem_rdata into rdata_reg; byte_cnt=0 -> RSEND.
- RSEND:
  - tx_valid=1, tx_data = rdata_reg[8*byte_cnt +: 8].
  - tx_data is held stable until a transfer (tx_valid && tx_ready).
  - on each transfer, byte_cnt++.
  - after transfer number RESP_BYTES -> IDLE, with tx_valid low that cycle.
  - tx_valid never drops without a transfer.
- Dropped bytes: rx_valid in WCOMMIT, RREQ, RWAIT or RSEND discards the byte and sets overrun=1. overrun clears only on reset.
- mem_addr and mem_wdata hold their last values between commands.
- byte_cnt is 2 bits and wraps only via explicit clear.
- Header addr 0x7F is legal; no address range check.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - a counter clears on every rx_valid and on entry to WDATA, and increments each cycle in WDATA.
  - on reaching TIMEOUT_CYCLES-1 without a byte: discard the partial word, no mem_we, pulse timeout_err for 1 cycle, go to IDLE.
  - a byte arriving on the terminal-count cycle wins; no timeout fires.
- Undefined:
  - no counter logic; WDATA waits indefinitely; timeout_err is constant 0.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - state encoding enum (6 states).
  - CMD_WE_BIT=7, CMD_ADDR_W=7, WORD_BYTES=4.
  - default TIMEOUT_CYCLES constant, shared with the uart module's baud constants.
- One sub-module is natural: uart_cmd_timeout (the loadable gap counter), instantiated only under CMD_TIMEOUT_EN.
- The FSM and datapath stay flat in uart_cmd_decoder.

Test Plan:
- Write: bytes 0x85, 0x34, 0x12, 0x00, 0x20 -> one mem_we pulse 1 cycle after the 5th rx_valid, with mem_addr=5 and mem_wdata=0x20001234; no mem_re, tx_valid stays 0.
- Read, RESP_BYTES=1: byte 0x05, memory returns 0x000000AB -> mem_re pulses with addr 5; tx_valid rises 2 cycles later with tx_data=0xAB.
  - With tx_ready held low for 10 cycles: tx_valid and tx_data stay stable, then 1 transfer and back to IDLE (busy=0).
- Read, RESP_BYTES=4: memory returns 0xDEADBEEF -> transfers 0xEF, 0xBE, 0xAD, 0xDE in order.
- Overrun: rx_valid during RSEND -> byte ignored, overrun=1 and stays 1; the next header is decoded normally.
- Reset mid-write: after 0x81 and 2 data bytes, pulse reset low -> all outputs 0, no mem_we.
  - A following complete write to addr 1 commits the correct word, with no leftover bytes.
- CMD_TIMEOUT_EN with TIMEOUT_CYCLES=50: header 0x82 plus 1 byte, then silence -> timeout_err pulse at cycle 50 of the gap, no mem_we, busy=0.
  - A byte arriving at gap cycle 49 keeps the command alive.
